// File: rtl/monitor_alarme_reator.sv
// Reactor alarm sequencer: confirms limit violations over consecutive valid samples,
// drives the annunciators, runs the operator acknowledge and escalates to a sticky shutdown.
module monitor_alarme_reator #(
    parameter int unsigned LIMITE_TEMP     = 40,
    parameter int unsigned LIMITE_PRESSAO  = 12,
    parameter int unsigned LIMITE_RADIACAO = 2048,
    parameter int unsigned N_CONFIRMA      = 3,
    parameter int unsigned T_ESCALA        = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        amostraValida,
    input  logic [7:0]  temp,
    input  logic [3:0]  pressao,
    input  logic [11:0] radiacao,
    input  logic        reconhecer,
    output logic        alarmeSonoro,
    output logic        alarmeVisual,
    output logic        desligarReator,
    output logic [2:0]  causa,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        SUSPEITA    = 2'd1,
        ALARME      = 2'd2,
        RECONHECIDO = 2'd3
    } estado_t;

    localparam logic [3:0]  N_CONF   = 4'(N_CONFIRMA);
    localparam logic [15:0] T_ULTIMO = 16'(T_ESCALA - 1);

    estado_t     st;
    logic [3:0]  cnt;
    logic [15:0] timer;
    logic [2:0]  v;
    logic        viola;
    logic        limpa;

    assign v = {radiacao > 12'(LIMITE_RADIACAO),
                pressao  > 4'(LIMITE_PRESSAO),
                temp     > 8'(LIMITE_TEMP)};
    assign viola  = amostraValida && (|v);
    assign limpa  = amostraValida && !(|v);
    assign estado = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st             <= NORMAL;
            cnt            <= '0;
            timer          <= '0;
            causa          <= '0;
            alarmeSonoro   <= 1'b0;
            alarmeVisual   <= 1'b0;
            desligarReator <= 1'b0;
        end else begin
            case (st)
                NORMAL: begin
                    if (viola) begin
                        cnt   <= 4'd1;
                        causa <= v;
                        if (N_CONF == 4'd1) begin
                            st           <= ALARME;
                            timer        <= '0;
                            alarmeSonoro <= 1'b1;
                            alarmeVisual <= 1'b1;
                        end else begin
                            st <= SUSPEITA;
                        end
                    end
                end
                SUSPEITA: begin
                    if (viola) begin
                        cnt   <= cnt + 4'd1;
                        causa <= causa | v;
                        if (cnt + 4'd1 == N_CONF) begin
                            st           <= ALARME;
                            timer        <= '0;
                            alarmeSonoro <= 1'b1;
                            alarmeVisual <= 1'b1;
                        end
                    end else if (limpa) begin
                        st    <= NORMAL;
                        cnt   <= '0;
                        causa <= '0;
                    end
                end
                ALARME: begin
                    if (viola)
                        causa <= causa | v;
                    // Acknowledge takes priority over the escalation on the same edge.
                    if (reconhecer) begin
                        st           <= RECONHECIDO;
                        alarmeSonoro <= 1'b0;
                    end else if (timer == T_ULTIMO) begin
                        desligarReator <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RECONHECIDO: begin
                    if (viola) begin
                        causa <= causa | v;
                    end else if (limpa) begin
                        st           <= NORMAL;
                        cnt          <= '0;
                        causa        <= '0;
                        alarmeVisual <= 1'b0;
                    end
                end
                default: st <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_alarme_reator.sv
// Bench for monitor_alarme_reator: vector table, directed multi-cycle sequences,
// and randomized traffic against an event-level reference model.
module tb_monitor_alarme_reator;

    localparam int N_C = 3;
    localparam int T_E = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        amostraValida = 1'b0;
    logic [7:0]  temp = '0;
    logic [3:0]  pressao = '0;
    logic [11:0] radiacao = '0;
    logic        reconhecer = 1'b0;
    logic        alarmeSonoro, alarmeVisual, desligarReator;
    logic [2:0]  causa;
    logic [1:0]  estado;

    int n_vec = 0;
    int n_err = 0;

    monitor_alarme_reator #(
        .LIMITE_TEMP(40), .LIMITE_PRESSAO(12), .LIMITE_RADIACAO(2048),
        .N_CONFIRMA(N_C), .T_ESCALA(T_E)
    ) dut (
        .clk(clk), .rst_n(rst_n), .amostraValida(amostraValida),
        .temp(temp), .pressao(pressao), .radiacao(radiacao),
        .reconhecer(reconhecer), .alarmeSonoro(alarmeSonoro),
        .alarmeVisual(alarmeVisual), .desligarReator(desligarReator),
        .causa(causa), .estado(estado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        val;
        logic [7:0]  t;
        logic [3:0]  p;
        logic [11:0] r;
        logic        rec;
        logic [1:0]  e_est;
        logic        e_son;
        logic        e_vis;
        logic [2:0]  e_causa;
    } vec_t;

    vec_t tbl [23];

    // Reference model: stage of the alarm story, run length of violations,
    // and number of unacknowledged edges spent alarming.
    int         m_st;
    int         m_run;
    int         m_age;
    logic [2:0] m_causa;
    logic       m_des;

    task automatic chk(input string name, input logic [1:0] e_est, input logic e_son,
                       input logic e_vis, input logic e_des, input logic [2:0] e_causa);
        n_vec++;
        if ({estado, alarmeSonoro, alarmeVisual, desligarReator, causa} !==
            {e_est, e_son, e_vis, e_des, e_causa}) begin
            n_err++;
            $display("FAIL %s: got estado=%0d son=%b vis=%b des=%b causa=%b, want estado=%0d son=%b vis=%b des=%b causa=%b",
                     name, estado, alarmeSonoro, alarmeVisual, desligarReator, causa,
                     e_est, e_son, e_vis, e_des, e_causa);
        end
    endtask

    task automatic drive(input logic val, input logic [7:0] t, input logic [3:0] p,
                         input logic [11:0] r, input logic rec);
        amostraValida = val;
        temp          = t;
        pressao       = p;
        radiacao      = r;
        reconhecer    = rec;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'd0, 4'd0, 12'd0, 1'b0);
        rst_n = 1'b0;
        m_st = 0; m_run = 0; m_age = 0; m_causa = '0; m_des = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic model_step(input logic val, input logic [7:0] t, input logic [3:0] p,
                              input logic [11:0] r, input logic rec);
        logic [2:0] vv;
        logic viol;
        vv   = {r > 12'd2048, p > 4'd12, t > 8'd40};
        viol = val && (vv != 3'b000);
        if (m_st == 0) begin
            if (viol) begin
                m_run = 1; m_causa = vv;
                if (m_run >= N_C) begin m_st = 2; m_age = 0; end
                else m_st = 1;
            end
        end else if (m_st == 1) begin
            if (viol) begin
                m_run++; m_causa |= vv;
                if (m_run >= N_C) begin m_st = 2; m_age = 0; end
            end else if (val) begin
                m_st = 0; m_run = 0; m_causa = '0;
            end
        end else if (m_st == 2) begin
            if (viol) m_causa |= vv;
            if (rec) m_st = 3;
            else begin
                m_age++;
                if (m_age >= T_E) m_des = 1'b1;
            end
        end else begin
            if (viol) m_causa |= vv;
            else if (val) begin m_st = 0; m_run = 0; m_causa = '0; end
        end
    endtask

    task automatic enter_alarm_temp();
        for (int i = 0; i < N_C; i++) begin
            drive(1'b1, 8'd41, 4'd0, 12'd0, 1'b0);
            tick();
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'd41, 4'd0,  12'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b001};
        tbl[1]  = '{1'b1, 8'd41, 4'd0,  12'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b001};
        tbl[2]  = '{1'b1, 8'd41, 4'd0,  12'd0, 1'b0, 2'd2, 1'b1, 1'b1, 3'b001};
        tbl[3]  = '{1'b0, 8'd0,  4'd0,  12'd0, 1'b1, 2'd3, 1'b0, 1'b1, 3'b001};
        tbl[4]  = '{1'b1, 8'd0,  4'd0,  12'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000};
        tbl[5]  = '{1'b1, 8'd50, 4'd0,  12'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b001};
        tbl[6]  = '{1'b1, 8'd50, 4'd0,  12'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b001};
        tbl[7]  = '{1'b1, 8'd30, 4'd0,  12'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000};
        tbl[8]  = '{1'b1, 8'd40, 4'd12, 12'd2048, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000};
        tbl[9]  = '{1'b1, 8'd40, 4'd0,  12'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000};
        tbl[10] = '{1'b1, 8'd40, 4'd0,  12'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000};
        tbl[11] = '{1'b0, 8'd99, 4'd15, 12'd4095, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000};
        tbl[12] = '{1'b1, 8'd41, 4'd0,  12'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b001};
        tbl[13] = '{1'b0, 8'd0,  4'd0,  12'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b001};
        tbl[14] = '{1'b1, 8'd41, 4'd0,  12'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b001};
        tbl[15] = '{1'b0, 8'd0,  4'd0,  12'd0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b001};
        tbl[16] = '{1'b1, 8'd41, 4'd0,  12'd0, 1'b0, 2'd2, 1'b1, 1'b1, 3'b001};
        tbl[17] = '{1'b1, 8'd0,  4'd0,  12'd0, 1'b0, 2'd2, 1'b1, 1'b1, 3'b001};
        tbl[18] = '{1'b1, 8'd0,  4'd0,  12'd0, 1'b1, 2'd3, 1'b0, 1'b1, 3'b001};
        tbl[19] = '{1'b1, 8'd0,  4'd0,  12'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000};
        tbl[20] = '{1'b1, 8'd0,  4'd0,  12'd0, 1'b1, 2'd0, 1'b0, 1'b0, 3'b000};
        tbl[21] = '{1'b1, 8'd0,  4'd13, 12'd0, 1'b1, 2'd1, 1'b0, 1'b0, 3'b010};
        tbl[22] = '{1'b1, 8'd0,  4'd0,  12'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000};

        do_reset();
        chk("reset", 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].val, tbl[i].t, tbl[i].p, tbl[i].r, tbl[i].rec);
            tick();
            chk($sformatf("tbl[%0d]", i), tbl[i].e_est, tbl[i].e_son, tbl[i].e_vis,
                1'b0, tbl[i].e_causa);
        end

        // Pressure alarm, radiation joins, acknowledge on the 5th alarm cycle.
        for (int i = 0; i < N_C; i++) begin
            drive(1'b1, 8'd0, 4'd13, 12'd0, 1'b0);
            tick();
        end
        chk("press_alarm", 2'd2, 1'b1, 1'b1, 1'b0, 3'b010);
        drive(1'b1, 8'd0, 4'd13, 12'd2049, 1'b0);
        tick();
        chk("rad_joins", 2'd2, 1'b1, 1'b1, 1'b0, 3'b110);
        drive(1'b0, 8'd0, 4'd0, 12'd0, 1'b0);
        tick(); tick(); tick();
        drive(1'b0, 8'd0, 4'd0, 12'd0, 1'b1);
        tick();
        chk("ack_5th", 2'd3, 1'b0, 1'b1, 1'b0, 3'b110);
        drive(1'b1, 8'd0, 4'd0, 12'd0, 1'b0);
        tick();
        chk("ack_clean", 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Unacknowledged alarm escalates exactly T_ESCALA edges after entry.
        enter_alarm_temp();
        drive(1'b0, 8'd0, 4'd0, 12'd0, 1'b0);
        for (int i = 1; i < T_E; i++) tick();
        chk("esc_edge_T-1", 2'd2, 1'b1, 1'b1, 1'b0, 3'b001);
        tick();
        chk("esc_edge_T", 2'd2, 1'b1, 1'b1, 1'b1, 3'b001);
        drive(1'b0, 8'd0, 4'd0, 12'd0, 1'b1);
        tick();
        chk("esc_ack", 2'd3, 1'b0, 1'b1, 1'b1, 3'b001);
        drive(1'b1, 8'd0, 4'd0, 12'd0, 1'b0);
        tick();
        chk("esc_sticky", 2'd0, 1'b0, 1'b0, 1'b1, 3'b000);
        enter_alarm_temp();
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_alarm", 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        rst_n = 1'b1;

        // Acknowledge on the last timer edge wins over escalation.
        enter_alarm_temp();
        drive(1'b0, 8'd0, 4'd0, 12'd0, 1'b0);
        for (int i = 1; i < T_E; i++) tick();
        drive(1'b0, 8'd0, 4'd0, 12'd0, 1'b1);
        tick();
        chk("ack_vs_esc", 2'd3, 1'b0, 1'b1, 1'b0, 3'b001);
        drive(1'b0, 8'd0, 4'd0, 12'd0, 1'b0);
        tick();
        chk("ack_vs_esc_hold", 2'd3, 1'b0, 1'b1, 1'b0, 3'b001);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic       val, rec;
            logic [7:0] t;
            logic [3:0] p;
            logic [11:0] r;
            val = ($urandom_range(0, 9) < 7);
            t   = 8'($urandom_range(0, 44));
            p   = 4'($urandom_range(0, 13));
            r   = 12'($urandom_range(2000, 2052));
            rec = ($urandom_range(0, 15) == 0);
            drive(val, t, p, r, rec);
            model_step(val, t, p, r, rec);
            tick();
            chk($sformatf("rand[%0d]", i), 2'(m_st), m_st == 2, m_st >= 2, m_des, m_causa);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
